// File: rtl/bowling_pkg.sv
// Shared definitions for the bowling scorer control path: state encoding,
// game dimensions and the pin-count width.
package bowling_pkg;

  localparam int NUM_FRAMES = 10;
  localparam int MAX_PINS   = 10;
  localparam int PIN_W      = 4;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT1      = 4'd1,
    S_ADD1       = 4'd2,
    S_EVAL1      = 4'd3,
    S_WAIT2      = 4'd4,
    S_ADD2       = 4'd5,
    S_EVAL2      = 4'd6,
    S_BONUS_WAIT = 4'd7,
    S_BONUS_ADD  = 4'd8,
    S_BONUS_EVAL = 4'd9,
    S_NEXTF      = 4'd10,
    S_CHKLF      = 4'd11,
    S_GAME_OVER  = 4'd12
  } state_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_WAIT1) || (s == S_WAIT2) || (s == S_BONUS_WAIT);
  endfunction

endpackage

// File: rtl/game_controller_throw_check.sv
// Pin-count legality: a throw may not knock down more pins than are standing.
module throw_check #(
  parameter int MAX_PINS = bowling_pkg::MAX_PINS
) (
  input  logic [bowling_pkg::PIN_W-1:0] n,
  input  logic                          fresh,
  input  logic [bowling_pkg::PIN_W-1:0] n_first,
  output logic                          legal
);

  logic [bowling_pkg::PIN_W:0] total;

  // On a partial rack the pins already down count against the limit.
  always_comb begin
    total = 5'd0;
    if (fresh) begin
      total = {1'b0, n};
    end else begin
      total = {1'b0, n} + {1'b0, n_first};
    end
    legal = (total <= 5'(MAX_PINS));
  end

endmodule

// File: rtl/game_controller.sv
// Bowling scorer control FSM: accepts throws, sequences frames and 10th-frame
// bonus throws, and drives the datapath strobes FT/AD/NF.
module game_controller #(
  parameter int NUM_FRAMES = bowling_pkg::NUM_FRAMES,
  parameter int MAX_PINS   = bowling_pkg::MAX_PINS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          throw_valid,
  input  logic [bowling_pkg::PIN_W-1:0] N,
  input  logic                          APD,
  input  logic                          LF,
  output logic                          ready,
  output logic                          FT,
  output logic                          AD,
  output logic                          NF,
  output logic [bowling_pkg::PIN_W-1:0] frame,
  output logic                          game_over,
  output logic                          err_pins,
  output logic                          sync_err
);

  import bowling_pkg::*;

  state_t             state;
  state_t             next_state;
  logic [PIN_W-1:0]   n_first;
  logic [PIN_W-1:0]   nf_cnt;
  logic [1:0]         bonus_left;
  logic               fresh;
  logic               rack_fresh;
  logic               legal;
  logic               in_wait;
  logic               accept;
  logic               reject;
  logic               last_frame;
  logic               game_done;

  assign in_wait    = is_wait_state(state);
  assign rack_fresh = (state == S_WAIT1) || ((state == S_BONUS_WAIT) && fresh);
  assign accept     = throw_valid && in_wait && legal;
  assign reject     = throw_valid && in_wait && !legal;
  assign last_frame = (frame == 4'(NUM_FRAMES));
  assign game_done  = (nf_cnt == 4'(NUM_FRAMES));

  throw_check #(.MAX_PINS(MAX_PINS)) u_throw_check (
    .n       (N),
    .fresh   (rack_fresh),
    .n_first (n_first),
    .legal   (legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start) next_state = S_WAIT1;
        else       next_state = state;
      end
      S_WAIT1: begin
        if (accept) next_state = S_ADD1;
        else        next_state = S_WAIT1;
      end
      S_ADD1: next_state = S_EVAL1;
      S_EVAL1: begin
        if (!APD)           next_state = S_WAIT2;
        else if (last_frame) next_state = S_BONUS_WAIT;
        else                next_state = S_NEXTF;
      end
      S_WAIT2: begin
        if (accept) next_state = S_ADD2;
        else        next_state = S_WAIT2;
      end
      S_ADD2: next_state = S_EVAL2;
      S_EVAL2: begin
        if (APD && last_frame) next_state = S_BONUS_WAIT;
        else                   next_state = S_NEXTF;
      end
      S_BONUS_WAIT: begin
        if (accept) next_state = S_BONUS_ADD;
        else        next_state = S_BONUS_WAIT;
      end
      S_BONUS_ADD: next_state = S_BONUS_EVAL;
      S_BONUS_EVAL: begin
        if (bonus_left == 2'd1) next_state = S_NEXTF;
        else                    next_state = S_BONUS_WAIT;
      end
      S_NEXTF: next_state = S_CHKLF;
      S_CHKLF: begin
        if (game_done) next_state = S_GAME_OVER;
        else           next_state = S_WAIT1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Rack/frame bookkeeping and sticky LF cross-check.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame      <= 4'd1;
      n_first    <= 4'd0;
      nf_cnt     <= 4'd0;
      bonus_left <= 2'd0;
      fresh      <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            frame      <= 4'd1;
            nf_cnt     <= 4'd0;
            bonus_left <= 2'd0;
            fresh      <= 1'b1;
            sync_err   <= 1'b0;
          end
        end
        S_EVAL1: begin
          if (!APD) begin
            n_first <= N;
          end else if (last_frame) begin
            bonus_left <= 2'd2;
            fresh      <= 1'b1;
          end
        end
        S_EVAL2: begin
          if (APD && last_frame) begin
            bonus_left <= 2'd1;
            fresh      <= 1'b1;
          end
        end
        S_BONUS_EVAL: begin
          bonus_left <= bonus_left - 2'd1;
          if (fresh && APD) begin
            fresh <= 1'b1;
          end else begin
            fresh   <= 1'b0;
            n_first <= N;
          end
        end
        S_NEXTF: begin
          nf_cnt <= nf_cnt + 4'd1;
          if (!last_frame) frame <= frame + 4'd1;
        end
        S_CHKLF: begin
          if (LF != game_done) sync_err <= 1'b1;
        end
        default: begin
          frame <= frame;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 1'b0;
      FT        <= 1'b0;
      AD        <= 1'b0;
      NF        <= 1'b0;
      game_over <= 1'b0;
      err_pins  <= 1'b0;
    end else begin
      ready     <= is_wait_state(next_state);
      FT        <= (next_state == S_ADD1) || (next_state == S_EVAL1) ||
                   (((next_state == S_BONUS_ADD) || (next_state == S_BONUS_EVAL)) && fresh);
      AD        <= (next_state == S_ADD1) || (next_state == S_ADD2) || (next_state == S_BONUS_ADD);
      NF        <= (next_state == S_NEXTF);
      game_over <= (next_state == S_GAME_OVER);
      err_pins  <= reject;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: a bowling-rules model predicts AD/NF/
// err/game-over events, a monitor compares them as the DUT produces them.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       throw_valid = 1'b0;
  logic [3:0] N = 4'd0;
  logic       APD = 1'b0;
  logic       LF = 1'b0;
  logic       ready, FT, AD, NF, game_over, err_pins, sync_err;
  logic [3:0] frame;

  int checks = 0;
  int errors = 0;

  typedef enum {EV_AD, EV_NF, EV_ERR, EV_GO} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    logic     ft;
    int       frm;
  } ev_t;
  ev_t exp_q[$];

  // Bowling-rules model state
  int pins_left;
  int mfrm;
  int bonus;
  bit fresh_m;
  bit second;
  bit over;
  int nf_seen = 0;
  bit lf_bad = 1'b0;
  logic go_prev = 1'b0;

  always #5 clk = ~clk;

  game_controller dut (
    .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid), .N(N),
    .APD(APD), .LF(LF), .ready(ready), .FT(FT), .AD(AD), .NF(NF),
    .frame(frame), .game_over(game_over), .err_pins(err_pins), .sync_err(sync_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Datapath stand-in: LF rises once ten frames have been closed.
  always @(negedge clk) begin
    if (NF === 1'b1) nf_seen++;
    LF = !lf_bad && (nf_seen == 10);
  end

  // Monitor: every strobe must match the head of the expected-event queue.
  always @(negedge clk) begin
    logic [3:0] act_bits;
    logic [3:0] exp_bits;
    ev_t e;
    act_bits = {AD, NF, err_pins, game_over && !go_prev};
    if (act_bits != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", act_bits, 4'd0);
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          EV_AD:   exp_bits = 4'b1000;
          EV_NF:   exp_bits = 4'b0100;
          EV_ERR:  exp_bits = 4'b0010;
          default: exp_bits = 4'b0001;
        endcase
        check("event_kind", act_bits, exp_bits);
        if (e.kind == EV_AD) begin
          check("ad_ft", FT, e.ft);
          check("ad_frame", frame, e.frm);
        end
        if (e.kind == EV_NF) check("nf_frame", frame, e.frm);
      end
    end
    go_prev = game_over;
  end

  task automatic end_frame();
    exp_q.push_back('{EV_NF, 1'b0, mfrm});
    if (mfrm == 10) begin
      over = 1'b1;
      exp_q.push_back('{EV_GO, 1'b0, 0});
    end else begin
      mfrm++;
      pins_left = 10;
      fresh_m   = 1'b1;
      second    = 1'b0;
    end
  endtask

  task automatic model_throw(input int n);
    exp_q.push_back('{EV_AD, fresh_m, mfrm});
    pins_left -= n;
    if (bonus > 0) begin
      bonus--;
      if (fresh_m && pins_left == 0) pins_left = 10;
      else fresh_m = 1'b0;
      if (bonus == 0) end_frame();
    end else if (!second) begin
      if (pins_left == 0) begin
        if (mfrm == 10) begin
          bonus = 2; fresh_m = 1'b1; pins_left = 10;
        end else begin
          end_frame();
        end
      end else begin
        second = 1'b1; fresh_m = 1'b0;
      end
    end else begin
      if (pins_left == 0 && mfrm == 10) begin
        bonus = 1; fresh_m = 1'b1; pins_left = 10; second = 1'b0;
      end else begin
        end_frame();
      end
    end
  endtask

  function automatic int rand_n();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0 && pins_left < 15) return int'($urandom_range(pins_left + 1, 15));
    if (r == 1) return pins_left;
    return int'($urandom_range(0, pins_left));
  endfunction

  task automatic do_throw(input int n);
    int  waited;
    bit  legal;
    bit  apd_v;
    waited = 0;
    while (ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      check("ready_timeout", ready, 1'b1);
      over = 1'b1;
      return;
    end
    N = 4'(n);
    throw_valid = 1'b1;
    legal = (n <= pins_left);
    apd_v = (n == pins_left);
    if (legal) model_throw(n);
    else exp_q.push_back('{EV_ERR, 1'b0, 0});
    @(negedge clk);
    throw_valid = 1'b0;
    if (legal) APD = apd_v;
    else check("ready_after_reject", ready, 1'b1);
  endtask

  task automatic start_game(input bit bad);
    lf_bad = bad; nf_seen = 0;
    mfrm = 1; pins_left = 10; fresh_m = 1'b1; second = 1'b0; bonus = 0; over = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_frame", frame, 4'd1);
    check("start_game_over", game_over, 1'b0);
    check("start_sync_err", sync_err, 1'b0);
    check("start_ready", ready, 1'b1);
  endtask

  task automatic play_game(input int list[$], input bit bad);
    int guard;
    int n;
    guard = 0;
    start_game(bad);
    while (!over && guard < 200) begin
      if (list.size() > 0) n = list.pop_front();
      else n = rand_n();
      do_throw(n);
      guard++;
    end
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) @(negedge clk);
    check("event_drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("go_level", game_over, 1'b1);
    check("go_frame", frame, 4'd10);
    check("go_sync_err", sync_err, bad);
    check("go_ready", ready, 1'b0);
    // Throws after the game must be ignored; the monitor flags any strobe.
    N = 4'd3;
    throw_valid = 1'b1;
    repeat (4) @(negedge clk);
    throw_valid = 1'b0;
    check("go_hold", game_over, 1'b1);
  endtask

  initial begin
    int lst[$];
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_outputs", {FT, AD, NF, game_over, err_pins, sync_err}, 6'd0);
    check("rst_frame", frame, 4'd1);
    rst = 1'b0;

    lst = '{3, 4};
    play_game(lst, 1'b0);
    lst = '{10};
    play_game(lst, 1'b0);
    lst = '{7, 4, 3};
    play_game(lst, 1'b0);
    lst = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    play_game(lst, 1'b0);
    lst.delete();
    for (int i = 0; i < 18; i++) lst.push_back(0);
    lst.push_back(6); lst.push_back(4); lst.push_back(5);
    play_game(lst, 1'b0);
    lst.delete();
    for (int g = 0; g < 4; g++) play_game(lst, 1'b0);
    play_game(lst, 1'b1);

    // Reset while the second throw is being added.
    start_game(1'b0);
    do_throw(7);
    do_throw(2);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_ad", AD, 1'b0);
    check("midrst_outputs", {ready, FT, NF, game_over, err_pins, sync_err}, 6'd0);
    check("midrst_frame", frame, 4'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_idle_ready", ready, 1'b0);
    lst.delete();
    play_game(lst, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
